// File: rtl/nios_sysid_checker_pkg.sv
// Shared types and build-time defaults for the Nios system ID checker.
// The Avalon word addresses match the sysid peripheral register map.
package nios_sysid_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    FINISH
  } state_t;

  localparam logic [31:0] DEFAULT_EXPECTED_ID    = 32'h2345_6789;
  localparam logic [31:0] DEFAULT_EXPECTED_TS    = 32'h5F92_F33D;
  localparam int          DEFAULT_TIMEOUT_CYCLES = 256;

  localparam logic ID_ADDR = 1'b0;
  localparam logic TS_ADDR = 1'b1;

  // Maps a request state to the state that waits for its response.
  function automatic state_t wait_state_for(input state_t req_state);
    return (req_state == TS_REQ) ? TS_WAIT : ID_WAIT;
  endfunction

endpackage

// File: rtl/nios_sysid_checker.sv
// Boot-time system ID checker: reads the sysid ID and timestamp words over
// Avalon-MM and reports whether they match the values baked into this build.
module nios_sysid_checker
  import nios_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int            CW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic          expired;

  // The cycle in which the count sits at LAST_COUNT is the final cycle a
  // transaction may still complete; without progress it aborts on that edge.
  assign expired = (count_reg >= LAST_COUNT);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      avm_address <= ID_ADDR;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            count_reg   <= '0;
            avm_read    <= 1'b1;
            avm_address <= ID_ADDR;
            busy        <= 1'b1;
            state_reg   <= ID_REQ;
          end
        end

        ID_REQ, TS_REQ: begin
          // An accepted command wins over a timeout landing in the same cycle.
          if (!avm_waitrequest) begin
            avm_read  <= 1'b0;
            count_reg <= count_reg + 1'b1;
            state_reg <= wait_state_for(state_reg);
          end else if (expired) begin
            avm_read  <= 1'b0;
            timeout   <= 1'b1;
            pass      <= 1'b0;
            done      <= 1'b1;
            state_reg <= FINISH;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        ID_WAIT: begin
          if (avm_readdatavalid) begin
            id_value    <= avm_readdata;
            id_mismatch <= (avm_readdata != EXPECTED_ID);
            count_reg   <= '0;
            avm_read    <= 1'b1;
            avm_address <= TS_ADDR;
            state_reg   <= TS_REQ;
          end else if (expired) begin
            timeout   <= 1'b1;
            pass      <= 1'b0;
            done      <= 1'b1;
            state_reg <= FINISH;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        TS_WAIT: begin
          if (avm_readdatavalid) begin
            ts_value    <= avm_readdata;
            ts_mismatch <= (avm_readdata != EXPECTED_TS);
            pass        <= !id_mismatch && (avm_readdata == EXPECTED_TS);
            done        <= 1'b1;
            state_reg   <= FINISH;
          end else if (expired) begin
            timeout   <= 1'b1;
            pass      <= 1'b0;
            done      <= 1'b1;
            state_reg <= FINISH;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        FINISH: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          avm_read  <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/nios_sysid_checker.md
# nios_sysid_checker

Avalon-MM master that interrogates the system ID peripheral after reset and verifies it. On a start pulse it reads the ID word (address 0), then the timestamp word (address 1), compares each against build-time expected values, and reports pass/fail/timeout. It sits beside the Nios core on the same interconnect and gates boot diagnostics: the LED/status logic consumes `pass` and `done`.

## Interface
- `EXPECTED_ID`, 32'h2345_6789, expected word at address 0
- `EXPECTED_TS`, 32'h5F92_F33D, expected word at address 1
- `TIMEOUT_CYCLES`, 256, max cycles per read transaction (request through readdatavalid); ≥2
- `clock` in 1, sole clock
- `reset_n` in 1, synchronous, active-low reset
- `start` in 1, single-cycle request to run a check
- `avm_address` out 1, word address (0 = ID, 1 = timestamp)
- `avm_read` out 1, read request
- `avm_waitrequest` in 1, slave stall
- `avm_readdata` in 32, read data
- `avm_readdatavalid` in 1, read data qualifier
- `busy` out 1, check in progress
- `done` out 1, one-cycle pulse at completion (pass, fail or timeout)
- `pass` out 1, level; both words matched, held until next start
- `id_mismatch` out 1, level; ID word differed
- `ts_mismatch` out 1, level; timestamp word differed
- `timeout` out 1, level; a read exceeded TIMEOUT_CYCLES
- `id_value` out 32, captured ID word
- `ts_value` out 32, captured timestamp word

## Operation
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH.
- IDLE: `start`=1 → clear pass/mismatch/timeout flags and captured values, → ID_REQ.
- ID_REQ: `avm_read`=1, `avm_address`=0; held stable while `avm_waitrequest`=1. Accept (`avm_read` & !`avm_waitrequest`) → ID_WAIT, `avm_read`=0 next cycle.
- ID_WAIT: `avm_readdatavalid`=1 → capture `id_value`, set `id_mismatch` if ≠ EXPECTED_ID, → TS_REQ.
- TS_REQ/TS_WAIT: identical with address 1, `ts_value`, EXPECTED_TS, → FINISH.
- FINISH: `done`=1 for one cycle; `pass` = !id_mismatch & !ts_mismatch & !timeout; → IDLE.
- ID mismatch does not abort; timestamp is still read.
- Timeout: counter cleared on entering each REQ state, incremented every cycle in REQ/WAIT; reaching TIMEOUT_CYCLES → deassert `avm_read`, set `timeout`, → FINISH (pass=0). A readdatavalid arriving afterwards is ignored.
- `avm_readdatavalid` honoured only in WAIT states; ignored elsewhere.
- `start` while `busy`=1 ignored. `start` in FINISH cycle ignored; accepted from next IDLE cycle.
- `busy`=1 in all states except IDLE.

## Timing
- All outputs registered. Reset (`reset_n`=0 at a rising edge): state IDLE, all outputs 0, counter 0; takes effect on that edge even mid-transaction (`avm_read` drops next cycle; outstanding response ignored).
- Minimum latency (waitrequest=0, readdatavalid one cycle after accept): `start` sampled edge 0; `avm_read` high cycle 1 (addr 0); readdatavalid cycle 2; `avm_read` high cycle 3 (addr 1); readdatavalid cycle 4; `done`/flags valid cycle 5.
- Each waitrequest cycle or extra read-latency cycle adds one cycle.
- Flags and captured values hold until the next accepted `start` or reset.

## Structure
- Package `nios_sysid_checker_pkg`: state enum, default EXPECTED_ID/EXPECTED_TS/TIMEOUT_CYCLES constants, Avalon address constants (ID_ADDR=0, TS_ADDR=1).
- Single module; timeout counter inline, width $clog2(TIMEOUT_CYCLES+1). No sub-module.

## Test plan
- Slave returns 0x23456789 / 0x5F92F33D, waitrequest=0, 1-cycle latency, start pulse → reads at addr 0 then 1, `done` cycle 5, pass=1, no flags.
- Slave returns 0x23456788 for ID → id_mismatch=1, ts_mismatch=0, pass=0, id_value=0x23456788, timestamp still read.
- waitrequest high 3 cycles on each read, 2-cycle latency → `avm_read`/address stable while stalled, done at cycle 5+2×3+2×1=13, pass=1.
- Slave never asserts readdatavalid, TIMEOUT_CYCLES=8 → read dropped, timeout=1, pass=0, `done` pulse; late readdatavalid ignored.
- `start` re-pulsed while busy → ignored, single check completes; `reset_n`=0 in ID_WAIT → all outputs 0 next cycle, IDLE, later readdatavalid ignored.
